n2_issue_ctl: RTL and testbench
===============================

// Module: n2_issue_ctl
// PURPOSE
//  Issue controller between decode stage D2 and execute stage N2_exec.
//  - Generates the exec-valid strobe and the decode ready handshake.
//  - Stalls on load-use / load-WAW hazards via a register scoreboard.
//  - Sequences the second cycle of the two-cycle ALU.
//  - Squashes the decode/fetch pipe for a fixed window after an exec redirect.
// PARAMETERS
//  TWO_CYCLE_ALU  0  1: every issue takes 2 cycles (operand capture, then exec strobe)
//  FLUSH_CYCLES   2  cycles of squash after a redirect (>=1)
//  REGIDX_W       5  register index width; equals regindex_bits
// PORTS
//  clk            in   1         clock
//  resetn         in   1         reset, asynchronous, active-low
//  id_v_i         in   1         decoded instruction valid
//  id_rdy_o       out  1         instruction consumed this cycle (valid&ready handshake)
//  id_rs_use_i    in   2         [0] rs1 read, [1] rs2 read
//  id_rs1_i       in   REGIDX_W  source register 1
//  id_rs2_i       in   REGIDX_W  source register 2
//  id_rd_i        in   REGIDX_W  destination register (0 = none)
//  id_is_load_i   in   1         instruction is a load (result arrives later)
//  to_ex_v_o      out  1         exec strobe; drives N2_exec to_ex_v_i
//  ex_is_branch_i in   1         redirect taken from exec (is_branch_ex_o)
//  flush_o        out  1         squash fetch/decode
//  ld_done_v_i    in   1         load writeback valid
//  ld_done_rd_i   in   REGIDX_W  load writeback register
// BEHAVIOUR
//  Reset: state=RUN, scoreboard all 0, flush counter 0.
//   While resetn=0, id_rdy_o, to_ex_v_o and flush_o are forced 0.
//  Scoreboard sb[2**REGIDX_W]:
//   - Set: sb[id_rd_i] on a load handshake when rd != 0.
//   - Clear: sb[ld_done_rd_i] on ld_done_v_i.
//   - Same-index set and clear in one cycle: set wins.
//   - x0 is never busy.
//  hazard = (rs1 used & busy(rs1)) | (rs2 used & busy(rs2)) | (rd != 0 & busy(rd)),
//   where busy(r) = sb[r] & !(ld_done_v_i & ld_done_rd_i == r); same-cycle writeback bypasses.
//  FSM, ex_is_branch_i highest priority in every state:
//   - Redirect action: to_ex_v_o=0, id_rdy_o=0, flush_o=1, cnt<=FLUSH_CYCLES, goto FLUSH.
//   - RUN, TWO_CYCLE_ALU=0: id_rdy_o = to_ex_v_o = id_v_i & !hazard. Zero-latency combinational path.
//   - RUN, TWO_CYCLE_ALU=1: if id_v_i & !hazard, goto ALU2. id_rdy_o=0, to_ex_v_o=0.
//   - ALU2: to_ex_v_o=1, id_rdy_o=1, goto RUN. Decode holds operands stable through ALU2.
//   - FLUSH: flush_o=1, id_rdy_o=1 (discard), to_ex_v_o=0.
//     cnt decrements; leaving at cnt==1 goes to RUN.
//     A new redirect in FLUSH reloads cnt.
//  Redirect in ALU2: instruction aborted, not consumed.
//   The scoreboard bit is already set only for consumed loads, so no rollback.
//  Scoreboard is never cleared by flush; loads issued before a branch remain outstanding.
//  Throughput: 1 instruction/cycle (TWO_CYCLE_ALU=0), 1 per 2 cycles (=1).
// CONFIGURATION
//  Macro ISSUE_PERF_CNT_EN adds outputs issued_cnt_o, stall_cnt_o, flush_cnt_o, each 32 bits.
//   - issued_cnt_o: +1 per to_ex_v_o.
//   - stall_cnt_o: +1 per cycle with id_v_i & hazard in RUN.
//   - flush_cnt_o: +1 per redirect.
//   - Counters wrap at 2**32 and reset to 0.
//  Without ISSUE_PERF_CNT_EN: ports and logic are absent; behaviour otherwise identical.
// STRUCTURE
//  NanoCore_pkg: issue_state_e {RUN, ALU2, FLUSH}; the regindex_bits constant.
//  Sub-module n2_scoreboard: set/clear/bypassed-busy lookup for 3 read ports.
//  FSM and handshake logic live in the top.
// TESTING
//  1. ADD stream with id_v_i held 1, TWO_CYCLE_ALU=0 -> to_ex_v_o=1 every cycle, 10 issues in 10 cycles.
//  2. LW x5 then ADD x6,x5,x1; ld_done (x5) 3 cycles later -> ADD stalls 3 cycles.
//     ADD issues in the ld_done cycle (bypass).
//  3. ex_is_branch_i=1 with FLUSH_CYCLES=2 -> flush_o high 3 cycles, no to_ex_v_o.
//     Redirect again in FLUSH cycle 1 -> flush window extends.
//  4. TWO_CYCLE_ALU=1, 4 ADDs -> to_ex_v_o every other cycle, 4 strobes in 8 cycles.
//     Redirect in ALU2 -> no strobe, instruction not consumed.
//  5. LW x0 -> no scoreboard set. LW x7 set and ld_done x7 in the same cycle -> x7 stays busy.
//  6. resetn low mid-stall -> outputs 0, scoreboard clear.
//     After release, a pending ADD x6,x5 issues immediately.

Source files
------------

// File: rtl/NanoCore_pkg.sv
// NanoCore_pkg: shared issue-stage types and the register index width
package NanoCore_pkg;
  localparam int regindex_bits = 5;
  typedef enum logic [1:0] {RUN, ALU2, FLUSH} issue_state_e;
endpackage

// File: rtl/n2_scoreboard.sv
// n2_scoreboard: outstanding-load register bits with same-cycle writeback bypass on 3 lookups
module n2_scoreboard #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         set_v_i,
  input  logic [W-1:0] set_rd_i,
  input  logic         clr_v_i,
  input  logic [W-1:0] clr_rd_i,
  input  logic [W-1:0] r0_i,
  input  logic [W-1:0] r1_i,
  input  logic [W-1:0] r2_i,
  output logic [2:0]   busy_o
);
  logic [2**W-1:0] sb_q, sb_d;
  // next busy bits: clear first so a same-index set wins; x0 is never tracked
  always_comb begin
    sb_d = sb_q;
    if (clr_v_i) sb_d[clr_rd_i] = 1'b0;
    if (set_v_i) sb_d[set_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
  end
  // busy bit storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sb_q <= '0;
    else sb_q <= sb_d;
  end
  assign busy_o[0] = sb_q[r0_i] & !(clr_v_i && clr_rd_i == r0_i);
  assign busy_o[1] = sb_q[r1_i] & !(clr_v_i && clr_rd_i == r1_i);
  assign busy_o[2] = sb_q[r2_i] & !(clr_v_i && clr_rd_i == r2_i);
endmodule

// File: rtl/n2_issue_ctl.sv
// n2_issue_ctl: D2->exec issue handshake, load hazard stall, 2-cycle ALU and redirect squash; ISSUE_PERF_CNT_EN adds perf counters
module n2_issue_ctl
  import NanoCore_pkg::*;
#(
  parameter int TWO_CYCLE_ALU = 0,
  parameter int FLUSH_CYCLES  = 2,
  parameter int REGIDX_W      = regindex_bits
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                id_v_i,
  output logic                id_rdy_o,
  input  logic [1:0]          id_rs_use_i,
  input  logic [REGIDX_W-1:0] id_rs1_i,
  input  logic [REGIDX_W-1:0] id_rs2_i,
  input  logic [REGIDX_W-1:0] id_rd_i,
  input  logic                id_is_load_i,
  output logic                to_ex_v_o,
  input  logic                ex_is_branch_i,
  output logic                flush_o,
  input  logic                ld_done_v_i,
`ifdef ISSUE_PERF_CNT_EN
  input  logic [REGIDX_W-1:0] ld_done_rd_i,
  output logic [31:0]         issued_cnt_o,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`else
  input  logic [REGIDX_W-1:0] ld_done_rd_i
`endif
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       busy;
  logic             hazard, go, id_rdy, to_ex, flush;
  n2_scoreboard #(.W(REGIDX_W)) u_sb (
    .clk     (clk),
    .resetn  (resetn),
    .set_v_i (to_ex_v_o & id_is_load_i),
    .set_rd_i(id_rd_i),
    .clr_v_i (ld_done_v_i),
    .clr_rd_i(ld_done_rd_i),
    .r0_i    (id_rs1_i),
    .r1_i    (id_rs2_i),
    .r2_i    (id_rd_i),
    .busy_o  (busy)
  );
  assign hazard = (id_rs_use_i[0] & busy[0]) | (id_rs_use_i[1] & busy[1]) | busy[2];
  assign go     = id_v_i & !hazard;
  // issue FSM: redirect overrides every state; loads discarded in FLUSH never reach exec so never mark the scoreboard
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_rdy  = 1'b0;
    to_ex   = 1'b0;
    flush   = 1'b0;
    if (ex_is_branch_i) begin
      flush   = 1'b1;
      cnt_d   = CNT_W'(FLUSH_CYCLES);
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN: begin
          if (TWO_CYCLE_ALU != 0) state_d = go ? ALU2 : RUN;
          else begin
            id_rdy = go;
            to_ex  = go;
          end
        end
        ALU2: begin
          id_rdy  = 1'b1;
          to_ex   = 1'b1;
          state_d = RUN;
        end
        FLUSH: begin
          flush   = 1'b1;
          id_rdy  = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? RUN : FLUSH;
        end
        default: state_d = RUN;
      endcase
    end
  end
  // state and squash counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign id_rdy_o  = resetn & id_rdy;
  assign to_ex_v_o = resetn & to_ex;
  assign flush_o   = resetn & flush;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issued_cnt_q, issued_cnt_d, stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // free-running wrap-around event counters
  always_comb begin
    issued_cnt_d = issued_cnt_q + 32'(to_ex_v_o);
    stall_cnt_d  = stall_cnt_q + 32'(state_q == RUN && id_v_i && hazard);
    flush_cnt_d  = flush_cnt_q + 32'(ex_is_branch_i);
  end
  // counter storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
  assign issued_cnt_o = issued_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_n2_issue_ctl.sv
// tb_n2_issue_ctl: scoreboard-queue bench for single- and two-cycle issue controllers
module tb_n2_issue_ctl;
  logic       clk;
  logic       resetn;
  logic       id_v, id_ld, br, ldv;
  logic [1:0] use_r;
  logic [4:0] rs1, rs2, rd, ldrd;
  logic       rdy1, ex1, fl1, rdy2, ex2, fl2;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    string      tag;
    bit         sel;
    logic [2:0] exp;
  } exp_t;
  exp_t q[$];

  initial clk = 1'b1;
  always #5 clk = ~clk;

  n2_issue_ctl #(.TWO_CYCLE_ALU(0), .FLUSH_CYCLES(2)) dut1 (
    .clk(clk), .resetn(resetn), .id_v_i(id_v), .id_rdy_o(rdy1), .id_rs_use_i(use_r),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .id_is_load_i(id_ld), .to_ex_v_o(ex1),
    .ex_is_branch_i(br), .flush_o(fl1), .ld_done_v_i(ldv), .ld_done_rd_i(ldrd)
  );
  n2_issue_ctl #(.TWO_CYCLE_ALU(1), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .resetn(resetn), .id_v_i(id_v), .id_rdy_o(rdy2), .id_rs_use_i(use_r),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .id_is_load_i(id_ld), .to_ex_v_o(ex2),
    .ex_is_branch_i(br), .flush_o(fl2), .ld_done_v_i(ldv), .ld_done_rd_i(ldrd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected {id_rdy, to_ex_v, flush} per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, e.sel ? {29'd0, rdy2, ex2, fl2} : {29'd0, rdy1, ex1, fl1}, {29'd0, e.exp});
    end
  end

  task automatic ins(input logic v, input logic [1:0] u, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d, input logic l);
    id_v = v; use_r = u; rs1 = a; rs2 = b; rd = d; id_ld = l;
  endtask

  task automatic step(input string tag, input bit sel, input logic [2:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; br = 1'b0; ldv = 1'b0; ldrd = '0;
    ins(1, 2'b11, 5'd1, 5'd2, 5'd3, 0);
    #2;
    step("rst_v", 0, 3'b000);
    br = 1;
    step("rst_br", 0, 3'b000);
    br = 0; resetn = 1'b1;
    for (int i = 0; i < 10; i++) step($sformatf("add_stream%0d", i), 0, 3'b110);
    ins(1, 2'b01, 5'd1, 5'd0, 5'd5, 1);
    step("lw_x5", 0, 3'b110);
    ins(1, 2'b11, 5'd5, 5'd1, 5'd6, 0);
    for (int i = 0; i < 3; i++) step($sformatf("lduse_stall%0d", i), 0, 3'b000);
    ldv = 1; ldrd = 5'd5;
    step("lduse_bypass", 0, 3'b110);
    ldv = 0;
    step("x5_cleared", 0, 3'b110);
    ins(1, 2'b01, 5'd1, 5'd0, 5'd8, 1);
    step("lw_x8", 0, 3'b110);
    ins(1, 2'b00, 5'd0, 5'd0, 5'd8, 0);
    step("waw_stall", 0, 3'b000);
    ldv = 1; ldrd = 5'd8;
    step("waw_bypass", 0, 3'b110);
    ldv = 0;
    ins(1, 2'b11, 5'd1, 5'd2, 5'd3, 0);
    br = 1;
    step("redir", 0, 3'b001);
    br = 0;
    step("flush1", 0, 3'b101);
    step("flush2", 0, 3'b101);
    step("post_flush", 0, 3'b110);
    br = 1;
    step("redir_a", 0, 3'b001);
    br = 0;
    step("flush_a1", 0, 3'b101);
    br = 1;
    step("redir_in_flush", 0, 3'b001);
    br = 0;
    step("flush_b1", 0, 3'b101);
    step("flush_b2", 0, 3'b101);
    step("post_flush_b", 0, 3'b110);
    ins(1, 2'b01, 5'd1, 5'd0, 5'd0, 1);
    step("lw_x0", 0, 3'b110);
    ins(1, 2'b01, 5'd0, 5'd0, 5'd4, 0);
    step("use_x0", 0, 3'b110);
    ins(1, 2'b01, 5'd1, 5'd0, 5'd7, 1);
    ldv = 1; ldrd = 5'd7;
    step("lw_x7_setclr", 0, 3'b110);
    ldv = 0;
    ins(1, 2'b01, 5'd7, 5'd0, 5'd9, 0);
    step("x7_busy", 0, 3'b000);
    ldv = 1; ldrd = 5'd7;
    step("x7_done", 0, 3'b110);
    ldv = 0;
    ins(1, 2'b01, 5'd1, 5'd0, 5'd5, 1);
    step("lw_x5b", 0, 3'b110);
    ins(1, 2'b11, 5'd5, 5'd1, 5'd6, 0);
    step("stall_pre_rst", 0, 3'b000);
    resetn = 1'b0; br = 1;
    step("rst_mid_stall", 0, 3'b000);
    resetn = 1'b1; br = 0;
    step("post_rst_issue", 0, 3'b110);
    resetn = 1'b0;
    ins(1, 2'b11, 5'd1, 5'd2, 5'd3, 0);
    step("rst2_dut2", 1, 3'b000);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("alu2_cap%0d", i), 1, 3'b000);
      step($sformatf("alu2_ex%0d", i), 1, 3'b110);
    end
    step("alu2_cap_abort", 1, 3'b000);
    br = 1;
    step("alu2_redir", 1, 3'b001);
    br = 0;
    step("alu2_flush1", 1, 3'b101);
    step("alu2_flush2", 1, 3'b101);
    step("alu2_recap", 1, 3'b000);
    step("alu2_reissue", 1, 3'b110);
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
